button_debounce: RTL and testbench
==================================

// Module: button_debounce
// PURPOSE
//   Conditions raw push-button inputs from the iCE40-HX8K-EVB before they reach the
//   LED logic. Runs in the board clock domain (12 MHz).
//   Per channel, it synchronises the asynchronous pad input and filters contact bounce.
//   It outputs a clean active-high level, one-cycle press and release pulses, and a
//   press-toggled latch. Sits directly upstream of the leds block, whose but[] input
//   it drives.
// PARAMETERS
//   N          2       number of button channels
//   DEBOUNCE   120000  consecutive stable cycles needed to accept a new level (>=2; 10 ms at 12 MHz)
//   CNT_W      17      counter width; must satisfy 2**CNT_W > DEBOUNCE
//   ACTIVE_LOW 1       1: pad reads 0 when pressed; 0: pad reads 1 when pressed
// PORTS
//   clk       in   1  board clock, all logic on rising edge
//   rst_n     in   1  asynchronous, active-low reset
//   btn_raw   in   N  raw pad inputs, asynchronous to clk
//   but       out  N  debounced level, 1 = pressed (feeds leds.but)
//   press     out  N  one-cycle pulse on accepted press
//   release   out  N  one-cycle pulse on accepted release
//   toggle    out  N  inverts on every accepted press
// BEHAVIOUR
//   - Reset (rst_n=0, async):
//     - Both synchroniser stages load the "released" pad level (ACTIVE_LOW ? 1 : 0).
//     - Counters clear to 0.
//     - but, press, release and toggle are all 0.
//     - Outputs are registered, so they stay 0 until the first accepted event after release.
//   - Normalisation: s = sync2 ^ ACTIVE_LOW, so s = 1 means pressed.
//   - Synchroniser: 2-flop chain per channel (sync1 <= btn_raw; sync2 <= sync1). No logic between the flops.
//   - Per-channel filter, evaluated every rising edge:
//     - s == but: cnt <= 0 (any bounce back restarts the window).
//     - s != but and cnt < DEBOUNCE-1: cnt <= cnt+1.
//     - s != but and cnt == DEBOUNCE-1: but <= s; cnt <= 0; fire press (s=1) or release (s=0).
//   - Pulses are registered and high for exactly one cycle, in the same cycle that but changes.
//     A channel never shows press and release together.
//   - toggle[i] <= ~toggle[i] in the cycle press[i] fires.
//   - Latency: number rising edges so that edge 1 is the first edge sampling the new raw level.
//     A clean change updates but on edge DEBOUNCE+2.
//   - Counters saturate at DEBOUNCE-1, so there is no wrap-around. CNT_W truncation is forbidden
//     (elaboration-time check).
//   - Channels are fully independent. Simultaneous events on different channels each produce their own pulses in the same cycle.
//   - Held button: press fires once only. No auto-repeat.
//   - Glitch shorter than DEBOUNCE cycles after sync: no output change, counter returns to 0.
//   - Reset mid-count or mid-press: all state is lost immediately.
//     After release of rst_n, a still-held button is re-accepted as a new press after DEBOUNCE+2 edges.
// TESTING (bench uses DEBOUNCE=4, CNT_W=3, ACTIVE_LOW=1, N=2)
//   - Reset: rst_n=0 with btn_raw=2'b00.
//     -> but=0, press=0, release=0, toggle=0.
//     Hold btn_raw=00 after release -> press[1:0] pulses once, but=11 on edge 6.
//   - Clean press ch0: btn_raw 11->10.
//     -> but[0] rises on edge 6, press[0]=1 for exactly 1 cycle, toggle[0]=1, ch1 unchanged.
//   - Bounce ch0: 11->10 for 3 cycles, 11 for 1 cycle, then 10 steady.
//     -> no output for the first burst; but[0] rises 6 edges after the final transition; single press pulse.
//   - Release and second press ch0 (each held 10 cycles).
//     -> release[0] one-cycle pulse with but[0] falling.
//     -> second press[0] pulse returns toggle[0] to 0.
//   - Simultaneous: btn_raw 11->00 on one edge.
//     -> press=11 in the same cycle, both toggles flip, no release pulse.
//   - Reset mid-count: rst_n=0 two cycles after ch1 goes low, then released with button held.
//     -> outputs 0 during reset; press[1] fires 6 edges after rst_n deasserts.

Source files
------------

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - per-channel push-button synchroniser and bounce filter
// Emits a clean level, one-cycle press/release pulses and a press-toggled latch.
module button_debounce #(
  parameter int N          = 2,
  parameter int DEBOUNCE   = 120000,
  parameter int CNT_W      = 17,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] btn_raw,
  output logic [N-1:0] but,
  output logic [N-1:0] press,
  output logic [N-1:0] release_pulse,
  output logic [N-1:0] toggle
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE - 1);
  localparam logic [N-1:0]     IDLE_PAD = {N{ACTIVE_LOW}};

  if (DEBOUNCE < 2 || CNT_W > 62 || (64'd1 << CNT_W) <= 64'(DEBOUNCE)) begin : g_bad_params
    $error("button_debounce: DEBOUNCE must be >= 2 and fit in CNT_W bits");
  end

  logic [N-1:0]     sync1;
  logic [N-1:0]     sync2;
  logic [N-1:0]     s;
  logic [N-1:0]     accept;
  logic [CNT_W-1:0] cnt [N];

  assign s = sync2 ^ IDLE_PAD;

  always_comb begin
    accept = '0;
    for (int i = 0; i < N; i++) begin
      accept[i] = (s[i] != but[i]) && (cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= IDLE_PAD;
      sync2 <= IDLE_PAD;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Counter saturates at CNT_MAX: reaching it with a still-differing level is the accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
      but <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (s[i] == but[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          cnt[i] <= '0;
          but[i] <= s[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press         <= '0;
      release_pulse <= '0;
      toggle        <= '0;
    end else begin
      press         <= accept & s;
      release_pulse <= accept & ~s;
      toggle        <= toggle ^ (accept & s);
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - scoreboard bench for button_debounce (N=2, DEBOUNCE=4)
module tb_button_debounce;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] btn_raw;
  logic [1:0] but;
  logic [1:0] press;
  logic [1:0] release_pulse;
  logic [1:0] toggle;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [1:0] raw;
    logic [1:0] but;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] tog;
  } vec_t;

  vec_t       exp_q[$];
  vec_t       e;
  logic [1:0] eb;
  logic [1:0] et;

  button_debounce #(.N(2), .DEBOUNCE(4), .CNT_W(3), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .but(but),
    .press(press),
    .release_pulse(release_pulse),
    .toggle(toggle)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void push_quiet(input logic [1:0] raw, input int n);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back('{raw: raw, but: eb, press: 2'b00, rel: 2'b00, tog: et});
    end
  endfunction

  function automatic void push_event(input logic [1:0] raw, input logic [1:0] pr, input logic [1:0] rl);
    eb = (eb | pr) & ~rl;
    et = et ^ pr;
    exp_q.push_back('{raw: raw, but: eb, press: pr, rel: rl, tog: et});
  endfunction

  task automatic apply_reset(input logic [1:0] raw);
    rst_n   = 1'b0;
    btn_raw = raw;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    eb    = 2'b00;
    et    = 2'b00;
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    btn_raw = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({but, press, release_pulse, toggle} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_state: got but=%b press=%b release=%b toggle=%b, want all 0",
               but, press, release_pulse, toggle);
    end
    rst_n = 1'b1;
    eb    = 2'b00;
    et    = 2'b00;
    push_quiet(2'b00, 5);
    push_event(2'b00, 2'b11, 2'b00);
    push_quiet(2'b00, 3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      btn_raw = e.raw;
      @(posedge clk);
      #1;
      vectors++;
      if ({but, press, release_pulse, toggle} !== {e.but, e.press, e.rel, e.tog}) begin
        miscompares++;
        $display("FAIL held_after_reset: got but=%b press=%b release=%b toggle=%b, want %b %b %b %b",
                 but, press, release_pulse, toggle, e.but, e.press, e.rel, e.tog);
      end
    end
  endtask

  task automatic test_clean_press;
    apply_reset(2'b11);
    push_quiet(2'b11, 2);
    push_quiet(2'b10, 5);
    push_event(2'b10, 2'b01, 2'b00);
    push_quiet(2'b10, 4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      btn_raw = e.raw;
      @(posedge clk);
      #1;
      vectors++;
      if ({but, press, release_pulse, toggle} !== {e.but, e.press, e.rel, e.tog}) begin
        miscompares++;
        $display("FAIL clean_press: got but=%b press=%b release=%b toggle=%b, want %b %b %b %b",
                 but, press, release_pulse, toggle, e.but, e.press, e.rel, e.tog);
      end
    end
  endtask

  task automatic test_bounce;
    apply_reset(2'b11);
    push_quiet(2'b11, 2);
    push_quiet(2'b10, 3);
    push_quiet(2'b11, 1);
    push_quiet(2'b10, 5);
    push_event(2'b10, 2'b01, 2'b00);
    push_quiet(2'b10, 4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      btn_raw = e.raw;
      @(posedge clk);
      #1;
      vectors++;
      if ({but, press, release_pulse, toggle} !== {e.but, e.press, e.rel, e.tog}) begin
        miscompares++;
        $display("FAIL bounce: got but=%b press=%b release=%b toggle=%b, want %b %b %b %b",
                 but, press, release_pulse, toggle, e.but, e.press, e.rel, e.tog);
      end
    end
  endtask

  task automatic test_release_press;
    push_quiet(2'b11, 5);
    push_event(2'b11, 2'b00, 2'b01);
    push_quiet(2'b11, 4);
    push_quiet(2'b10, 5);
    push_event(2'b10, 2'b01, 2'b00);
    push_quiet(2'b10, 4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      btn_raw = e.raw;
      @(posedge clk);
      #1;
      vectors++;
      if ({but, press, release_pulse, toggle} !== {e.but, e.press, e.rel, e.tog}) begin
        miscompares++;
        $display("FAIL release_press: got but=%b press=%b release=%b toggle=%b, want %b %b %b %b",
                 but, press, release_pulse, toggle, e.but, e.press, e.rel, e.tog);
      end
    end
  endtask

  task automatic test_simultaneous;
    apply_reset(2'b11);
    push_quiet(2'b11, 2);
    push_quiet(2'b00, 5);
    push_event(2'b00, 2'b11, 2'b00);
    push_quiet(2'b00, 4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      btn_raw = e.raw;
      @(posedge clk);
      #1;
      vectors++;
      if ({but, press, release_pulse, toggle} !== {e.but, e.press, e.rel, e.tog}) begin
        miscompares++;
        $display("FAIL simultaneous: got but=%b press=%b release=%b toggle=%b, want %b %b %b %b",
                 but, press, release_pulse, toggle, e.but, e.press, e.rel, e.tog);
      end
    end
  endtask

  task automatic test_reset_mid;
    // Release both first so toggle is non-zero when reset strikes mid-count.
    push_quiet(2'b11, 5);
    push_event(2'b11, 2'b00, 2'b11);
    push_quiet(2'b11, 2);
    push_quiet(2'b01, 2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      btn_raw = e.raw;
      @(posedge clk);
      #1;
      vectors++;
      if ({but, press, release_pulse, toggle} !== {e.but, e.press, e.rel, e.tog}) begin
        miscompares++;
        $display("FAIL pre_reset_mid: got but=%b press=%b release=%b toggle=%b, want %b %b %b %b",
                 but, press, release_pulse, toggle, e.but, e.press, e.rel, e.tog);
      end
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({but, press, release_pulse, toggle} !== 8'h00) begin
      miscompares++;
      $display("FAIL async_reset: got but=%b press=%b release=%b toggle=%b, want all 0",
               but, press, release_pulse, toggle);
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({but, press, release_pulse, toggle} !== 8'h00) begin
      miscompares++;
      $display("FAIL in_reset: got but=%b press=%b release=%b toggle=%b, want all 0",
               but, press, release_pulse, toggle);
    end
    rst_n = 1'b1;
    eb    = 2'b00;
    et    = 2'b00;
    push_quiet(2'b01, 5);
    push_event(2'b01, 2'b10, 2'b00);
    push_quiet(2'b01, 3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      btn_raw = e.raw;
      @(posedge clk);
      #1;
      vectors++;
      if ({but, press, release_pulse, toggle} !== {e.but, e.press, e.rel, e.tog}) begin
        miscompares++;
        $display("FAIL reset_mid: got but=%b press=%b release=%b toggle=%b, want %b %b %b %b",
                 but, press, release_pulse, toggle, e.but, e.press, e.rel, e.tog);
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    btn_raw = 2'b00;
    eb      = 2'b00;
    et      = 2'b00;
    #1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_press();
    test_simultaneous();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
